// File: rtl/seg7_display_driver.sv
// Display stage for the seconds counter: latches a digit, decodes it to 7 segments,
// drives the segments with brightness PWM and blanking, and runs a lamp test after reset.
// Define DP_FLASH_EN to flash the decimal point for FLASH_CYCLES after each new digit.
module seg7_display_driver #(
  parameter logic [23:0] LAMP_CYCLES  = 24'd10_000_000,
  parameter logic [23:0] FLASH_CYCLES = 24'd1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_in,
  input  logic       digit_load,
  input  logic [2:0] brightness,
  input  logic       blank,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic       busy
);

  typedef enum logic {
    ST_LAMP,
    ST_DISPLAY
  } state_e;

  // Both counts must be >= 1; zero would break the lamp-test terminal count.
  if (LAMP_CYCLES == 24'd0 || FLASH_CYCLES == 24'd0) begin : g_bad_params
    $error("seg7_display_driver: LAMP_CYCLES and FLASH_CYCLES must be >= 1");
  end

  state_e      state_q, state_d;
  logic [3:0]  digit_q, digit_d;
  logic [23:0] lamp_cnt_q, lamp_cnt_d;
  logic [2:0]  pwm_cnt_q, pwm_cnt_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        busy_q, busy_d;
  logic        pwm_on;
  logic        lamp_done;
  logic        show;

`ifdef DP_FLASH_EN
  logic [23:0] flash_cnt_q, flash_cnt_d;
`endif

  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign pwm_on    = (pwm_cnt_q <= brightness);
  assign lamp_done = (lamp_cnt_q == LAMP_CYCLES - 24'd1);
  assign show      = pwm_on && !blank;

  always_comb begin
    state_d    = state_q;
    lamp_cnt_d = lamp_cnt_q;
    pwm_cnt_d  = pwm_cnt_q + 3'd1;
    digit_d    = digit_load ? digit_in : digit_q;
    seg_d      = '0;
    dp_d       = 1'b0;
    busy_d     = 1'b0;
`ifdef DP_FLASH_EN
    flash_cnt_d = flash_cnt_q;
`endif

    unique case (state_q)
      ST_LAMP: begin
        seg_d = '1;
        dp_d  = 1'b1;
        if (lamp_done) begin
          state_d = ST_DISPLAY;
          busy_d  = 1'b0;
        end else begin
          lamp_cnt_d = lamp_cnt_q + 24'd1;
          busy_d     = 1'b1;
        end
      end
      ST_DISPLAY: begin
        seg_d = show ? dec7(digit_q) : '0;
`ifdef DP_FLASH_EN
        dp_d = show && (flash_cnt_q != 24'd0);
        // A new load restarts the flash; otherwise the window runs down to zero.
        if (digit_load) begin
          flash_cnt_d = FLASH_CYCLES;
        end else if (flash_cnt_q != 24'd0) begin
          flash_cnt_d = flash_cnt_q - 24'd1;
        end
`endif
      end
      default: state_d = ST_LAMP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LAMP;
      digit_q    <= '0;
      lamp_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      busy_q     <= 1'b1;
`ifdef DP_FLASH_EN
      flash_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      lamp_cnt_q <= lamp_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      busy_q     <= busy_d;
`ifdef DP_FLASH_EN
      flash_cnt_q <= flash_cnt_d;
`endif
    end
  end

  assign seg_out = seg_q;
  assign dp_out  = dp_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_seg7_display_driver.sv
// Bench for seg7_display_driver: directed phases plus random stimulus, every cycle
// checked against a cycle-count model of lamp test, PWM window, decode and DP flash.
module tb_seg7_display_driver;

  localparam int LAMP  = 4;
  localparam int FLASH = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit_in = '0;
  logic       digit_load = 1'b0;
  logic [2:0] brightness = 3'd7;
  logic       blank = 1'b0;
  logic [6:0] seg_out;
  logic       dp_out;
  logic       busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  seg7_display_driver #(
    .LAMP_CYCLES (24'(LAMP)),
    .FLASH_CYCLES(24'(FLASH))
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digit_in  (digit_in),
    .digit_load(digit_load),
    .brightness(brightness),
    .blank     (blank),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: k = clock edges since the last reset edge; everything derives from it.
  int         k = 0;
  logic [3:0] m_digit = '0;
  int         last_load = -1000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [3:0] d,
                      input logic [2:0] br, input logic bl);
    logic [6:0] e_seg;
    logic       e_dp, e_busy, disp, on;
    @(negedge clk);
    reset = r; digit_load = ld; digit_in = d; brightness = br; blank = bl;
    @(posedge clk);
    #1;
    if (r) begin
      k = 0; m_digit = '0; last_load = -1000;
      e_seg = '0; e_dp = 1'b0; e_busy = 1'b1;
    end else begin
      k++;
      disp   = (k > LAMP);                       // state before this edge was DISPLAY
      on     = (((k - 1) % 8) <= int'(br));      // PWM counter value before this edge
      e_busy = (k < LAMP);
      if (!disp) begin
        e_seg = 7'h7F;
        e_dp  = 1'b1;
      end else begin
        e_seg = (on && !bl) ? dec_tab[m_digit] : 7'h00;
`ifdef DP_FLASH_EN
        e_dp = on && !bl && (k - last_load >= 1) && (k - last_load <= FLASH);
`else
        e_dp = 1'b0;
`endif
      end
      if (ld) begin
        m_digit = d;
        if (disp) last_load = k;
      end
    end
    check_eq("seg_out", 32'(seg_out), 32'(e_seg));
    check_eq("dp_out", 32'(dp_out), 32'(e_dp));
    check_eq("busy", 32'(busy), 32'(e_busy));
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 7, 0);
    step(1, 1, 4'h5, 7, 0);
    // Lamp test with blank asserted for part of it, then display digit 0
    for (int i = 0; i < LAMP + 4; i++) step(0, 0, 0, 7, i < 3);
    // Decode table at full brightness
    for (int d = 0; d < 16; d++) begin
      step(0, 1, 4'(d), 7, 0);
      step(0, 0, 0, 7, 0);
      step(0, 0, 0, 7, 0);
    end
    // PWM duty at brightness 0 and 3
    step(0, 1, 4'h8, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 3, 0);
    // Blank in display
    for (int i = 0; i < 4; i++) step(0, 0, 0, 7, 1);
    // Flash and reload during the flash
    step(0, 1, 4'h2, 7, 0);
    step(0, 0, 0, 7, 0);
    step(0, 1, 4'h3, 7, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 7, 0);
    // Reset mid-display with A shown, lamp test reruns
    step(0, 1, 4'hA, 7, 0);
    step(0, 0, 0, 7, 0);
    step(0, 0, 0, 7, 0);
    step(1, 0, 0, 7, 0);
    for (int i = 0; i < LAMP + 3; i++) step(0, 0, 0, 7, 0);
    // Load coinciding with the lamp->display transition
    step(1, 0, 0, 7, 0);
    for (int i = 0; i < LAMP + 3; i++) step(0, (i == LAMP - 1), 4'hC, 7, 0);
    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0),
           ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 1) == 0) ? 3'd7 : 3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
